// File: rtl/prog_delay_pkg.sv
// Shared types and width helpers for the programmable delay line.
package prog_delay_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  // Width of the dly port: must be able to express 0..MAX_DELAY.
  function automatic int dly_w(input int max_delay);
    return clog2(max_delay + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_delay_ram.sv
// Circular buffer storage: data array (no reset) plus per-entry valid bits
// that clear asynchronously so stale data can never surface after reset.
module prog_delay_ram #(
  parameter int    WIDTH     = 32,
  parameter int    DEPTH     = 16,
  parameter int    AW        = 4,
  parameter string RAM_STYLE = "distributed"
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wvld,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvld
);

  (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (we) begin
      r_vld[waddr] <= wvld;
    end
  end

  // Asynchronous read gives read-before-write when raddr == waddr.
  assign rdata = r_mem[raddr];
  assign rvld  = r_vld[raddr];

endmodule

// File: rtl/prog_delay.sv
// Programmable delay line (0..MAX_DELAY ce-cycles) with fill gating.
// Optional sticky out-of-range flag dly_err when PROG_DELAY_ERR_EN is defined.
//
// state | meaning
// FILL  | buffer not yet holding D fresh entries; outputs forced to 0
// RUN   | outputs show stored entry from D ce-edges ago (or din if D=0)
module prog_delay
  import prog_delay_pkg::*;
#(
  parameter int    WIDTH         = 32,
  parameter int    MAX_DELAY     = 16,
  parameter int    DEFAULT_DELAY = 3,
  parameter string RAM_STYLE     = "distributed"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ce,
  input  logic [WIDTH-1:0]              din,
  input  logic                          din_vld,
  input  logic [dly_w(MAX_DELAY)-1:0]   dly,
  input  logic                          dly_load,
  output logic [WIDTH-1:0]              dout,
  output logic                          dout_vld,
  output logic                          filling
`ifdef PROG_DELAY_ERR_EN
  ,
  output logic                          dly_err
`endif
);

  localparam int DW = dly_w(MAX_DELAY);
  localparam int AW = ptr_w(MAX_DELAY);
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW-1:0] DEF_D    = DW'(DEFAULT_DELAY);
  localparam logic [AW-1:0] PTR_LAST = AW'(MAX_DELAY - 1);
  localparam logic [AW:0]   MAX_EXT  = (AW+1)'(MAX_DELAY);

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_d, w_d_nxt;
  logic [DW-1:0]   r_fill_cnt, w_fill_nxt;
  logic [AW-1:0]   r_wr_ptr;
  logic [DW-1:0]   w_dly_clamp;
  logic [AW:0]     w_ptr_ext, w_d_ext;
  logic [AW-1:0]   w_raddr;
  logic [WIDTH-1:0] w_rd_data;
  logic            w_rd_vld;

  assign w_dly_clamp = (dly > MAX_D) ? MAX_D : dly;

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_fill_nxt  = r_fill_cnt;
    if (dly_load) begin
      // A load edge is never counted, even when ce writes on the same edge.
      w_d_nxt     = w_dly_clamp;
      w_fill_nxt  = '0;
      w_state_nxt = (w_dly_clamp == '0) ? RUN : FILL;
    end else if (ce && (r_state == FILL)) begin
      w_fill_nxt = r_fill_cnt + 1'b1;
      if (w_fill_nxt == r_d) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (DEFAULT_DELAY > 0) ? FILL : RUN;
      r_d        <= DEF_D;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_d        <= w_d_nxt;
      r_fill_cnt <= w_fill_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (ce) begin
      r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
    end
  end

  assign w_ptr_ext = {1'b0, r_wr_ptr};
  assign w_d_ext   = (AW+1)'(r_d);
  assign w_raddr   = (w_ptr_ext >= w_d_ext) ? AW'(w_ptr_ext - w_d_ext)
                                            : AW'(w_ptr_ext + MAX_EXT - w_d_ext);

  prog_delay_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (MAX_DELAY),
    .AW        (AW),
    .RAM_STYLE (RAM_STYLE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ce),
    .waddr (r_wr_ptr),
    .wdata (din),
    .wvld  (din_vld),
    .raddr (w_raddr),
    .rdata (w_rd_data),
    .rvld  (w_rd_vld)
  );

  always_comb begin
    dout     = '0;
    dout_vld = 1'b0;
    if (r_d == '0) begin
      dout_vld = din_vld;
      dout     = din_vld ? din : '0;
    end else if ((r_state == RUN) && w_rd_vld) begin
      dout_vld = 1'b1;
      dout     = w_rd_data;
    end
  end

  assign filling = (r_state == FILL);

`ifdef PROG_DELAY_ERR_EN
  logic r_dly_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_err <= 1'b0;
    end else if (dly_load && (dly > MAX_D)) begin
      r_dly_err <= 1'b1;
    end
  end

  assign dly_err = r_dly_err;
`endif

endmodule
